// File: rtl/cga_intr_level_arbiter.sv
// CGA interrupt priority-level arbiter: PID/PIE/PIL registers and level-change handshake.
// Optional IRQ two-flop synchronizer enabled by CGA_INTR_IRQ_SYNC_EN.
module cga_intr_level_arbiter (
  input  logic        MCLK,
  input  logic        RESET,
  input  logic        LOGSN,
  input  logic [15:0] FIDB,
  input  logic        LDPID,
  input  logic        LDPIE,
  input  logic        WRPIL,
  input  logic [14:0] IRQ,
  input  logic        CLRPID,
  input  logic [3:0]  CLRLVL,
  input  logic        LVACK,
  output logic        LVREQ,
  output logic [3:0]  LVNEW,
  output logic [3:0]  PIL,
  output logic [15:0] PID,
  output logic [15:0] PIE,
  output logic        INTPEND
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_HOLD
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] pid_q, pid_d;
  logic [15:0] pie_q, pie_d;
  logic [3:0]  pil_q, pil_d;
  logic [3:0]  lvnew_q, lvnew_d;
  logic        lvreq_q, lvreq_d;

  logic [14:0] irq_eff;
  logic [15:0] irq_mask;
  logic [15:0] clr_mask;
  logic [15:0] pend;
  logic [3:0]  highest;
  logic        above;
  logic        cond;

`ifdef CGA_INTR_IRQ_SYNC_EN
  logic [14:0] sync1_q, sync1_d;
  logic [14:0] sync2_q, sync2_d;

  assign sync1_d = IRQ;
  assign sync2_d = sync1_q;

  always_ff @(posedge MCLK) begin
    if (RESET) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign irq_eff = sync2_q;
`else
  assign irq_eff = IRQ;
`endif

  // Bit 0 has no IRQ line and is never cleared by CLRPID.
  assign irq_mask = {irq_eff, 1'b0};

  always_comb begin
    clr_mask = '0;
    if (CLRPID) clr_mask[CLRLVL] = 1'b1;
    clr_mask[0] = 1'b0;
  end

  assign pend = pid_q & pie_q;

  always_comb begin
    highest = '0;
    for (int i = 1; i < 16; i++)
      if (pend[i]) highest = 4'(i);
  end

  assign above   = highest > pil_q;
  assign cond    = !LOGSN && above;
  assign INTPEND = above;

  always_comb begin
    pid_d = ((LDPID ? FIDB : pid_q) & ~clr_mask) | irq_mask;
    pie_d = LDPIE ? FIDB : pie_q;
  end

  always_ff @(posedge MCLK) begin
    if (RESET) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (cond) state_d = S_REQ;
      S_REQ: begin
        if (LVACK)      state_d = S_HOLD;
        else if (LOGSN) state_d = S_IDLE;
      end
      S_HOLD: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    lvreq_d = state_d == S_REQ;
    lvnew_d = lvnew_q;
    pil_d   = pil_q;
    if (state_q == S_IDLE && cond) lvnew_d = highest;
    // An accepted level change overrides a concurrent PIL write.
    if (state_q == S_REQ && LVACK) pil_d = lvnew_q;
    else if (WRPIL)                pil_d = FIDB[11:8];
  end

  always_ff @(posedge MCLK) begin
    if (RESET) begin
      pid_q   <= '0;
      pie_q   <= '0;
      pil_q   <= '0;
      lvnew_q <= '0;
      lvreq_q <= 1'b0;
    end else begin
      pid_q   <= pid_d;
      pie_q   <= pie_d;
      pil_q   <= pil_d;
      lvnew_q <= lvnew_d;
      lvreq_q <= lvreq_d;
    end
  end

  assign LVREQ = lvreq_q;
  assign LVNEW = lvnew_q;
  assign PIL   = pil_q;
  assign PID   = pid_q;
  assign PIE   = pie_q;

endmodule

// File: tb/tb_cga_intr_level_arbiter.sv
// Directed vector bench for cga_intr_level_arbiter.
// Table rows apply one cycle of inputs and check all outputs after the edge.
module tb_cga_intr_level_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        logsn;
  logic [15:0] fidb;
  logic        ldpid, ldpie, wrpil;
  logic [14:0] irq;
  logic        clrpid;
  logic [3:0]  clrlvl;
  logic        lvack;
  logic        lvreq;
  logic [3:0]  lvnew, pil;
  logic [15:0] pid, pie;
  logic        intpend;

  int n_chk = 0;
  int n_fail = 0;

`ifdef CGA_INTR_IRQ_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  always #5 clk = ~clk;

  cga_intr_level_arbiter dut (
    .MCLK    (clk),
    .RESET   (rst),
    .LOGSN   (logsn),
    .FIDB    (fidb),
    .LDPID   (ldpid),
    .LDPIE   (ldpie),
    .WRPIL   (wrpil),
    .IRQ     (irq),
    .CLRPID  (clrpid),
    .CLRLVL  (clrlvl),
    .LVACK   (lvack),
    .LVREQ   (lvreq),
    .LVNEW   (lvnew),
    .PIL     (pil),
    .PID     (pid),
    .PIE     (pie),
    .INTPEND (intpend)
  );

  typedef struct {
    logic        ldpid, ldpie, wrpil;
    logic [15:0] fidb;
    logic [14:0] irq;
    logic        clr;
    logic [3:0]  lvl;
    logic        logsn, ack;
    logic        e_req;
    logic [3:0]  e_new, e_pil;
    logic [15:0] e_pid, e_pie;
    logic        e_int;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    logic a, logic b, logic c, logic [15:0] f, logic [14:0] q,
    logic cl, logic [3:0] lv, logic ls, logic ak,
    logic er, logic [3:0] en, logic [3:0] ep,
    logic [15:0] ed, logic [15:0] ee, logic ei);
    vec_t v;
    v.ldpid = a; v.ldpie = b; v.wrpil = c; v.fidb = f; v.irq = q;
    v.clr = cl; v.lvl = lv; v.logsn = ls; v.ack = ak;
    v.e_req = er; v.e_new = en; v.e_pil = ep;
    v.e_pid = ed; v.e_pie = ee; v.e_int = ei;
    return v;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_in();
    ldpid = 0; ldpie = 0; wrpil = 0; fidb = '0; irq = '0;
    clrpid = 0; clrlvl = '0; lvack = 0; logsn = 1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(int idx, vec_t v);
    ldpid = v.ldpid; ldpie = v.ldpie; wrpil = v.wrpil; fidb = v.fidb;
    irq = v.irq; clrpid = v.clr; clrlvl = v.lvl;
    logsn = v.logsn; lvack = v.ack;
    step();
    chk($sformatf("row%0d lvreq", idx), int'(lvreq), int'(v.e_req));
    chk($sformatf("row%0d lvnew", idx), int'(lvnew), int'(v.e_new));
    chk($sformatf("row%0d pil", idx), int'(pil), int'(v.e_pil));
    chk($sformatf("row%0d pid", idx), int'(pid), int'(v.e_pid));
    chk($sformatf("row%0d pie", idx), int'(pie), int'(v.e_pie));
    chk($sformatf("row%0d intpend", idx), int'(intpend), int'(v.e_int));
  endtask

  task automatic do_reset();
    idle_in();
    rst = 1;
    step();
    step();
    rst = 0;
  endtask

  initial begin
    int cnt;
    //          ld ld wr fidb     irq      cl lv ls ak  rq new pil pid      pie      int
    tbl.push_back(mk(0,1,0,16'hFFFF,15'h0000,0,0,0,0, 0, 0, 0,16'h0000,16'hFFFF,0));
    tbl.push_back(mk(0,0,0,16'h0000,15'h0200,0,0,0,0, 0, 0, 0,16'h0400,16'hFFFF,1));
    tbl.push_back(mk(0,0,0,16'h0000,15'h0000,0,0,0,0, 1,10, 0,16'h0400,16'hFFFF,1));
    tbl.push_back(mk(0,0,0,16'h0000,15'h0000,0,0,0,1, 0,10,10,16'h0400,16'hFFFF,0));
    tbl.push_back(mk(0,0,0,16'h0000,15'h0000,0,0,0,0, 0,10,10,16'h0400,16'hFFFF,0));
    tbl.push_back(mk(0,0,0,16'h0000,15'h0000,0,0,0,0, 0,10,10,16'h0400,16'hFFFF,0));
    tbl.push_back(mk(0,0,0,16'h0000,15'h1400,0,0,0,0, 0,10,10,16'h2C00,16'hFFFF,1));
    tbl.push_back(mk(0,0,0,16'h0000,15'h0000,0,0,0,0, 1,13,10,16'h2C00,16'hFFFF,1));
    tbl.push_back(mk(0,0,0,16'h0000,15'h0000,0,0,0,1, 0,13,13,16'h2C00,16'hFFFF,0));
    tbl.push_back(mk(0,0,0,16'h0000,15'h0000,0,0,0,0, 0,13,13,16'h2C00,16'hFFFF,0));
    tbl.push_back(mk(0,0,0,16'h0000,15'h0000,0,0,0,0, 0,13,13,16'h2C00,16'hFFFF,0));
    tbl.push_back(mk(1,0,0,16'h0000,15'h0000,0,0,0,0, 0,13,13,16'h0000,16'hFFFF,0));
    tbl.push_back(mk(0,0,1,16'h0B00,15'h0000,0,0,0,0, 0,13,11,16'h0000,16'hFFFF,0));
    tbl.push_back(mk(0,0,0,16'h0000,15'h0800,0,0,0,0, 0,13,11,16'h1000,16'hFFFF,1));
    tbl.push_back(mk(0,0,0,16'h0000,15'h0000,0,0,0,0, 1,12,11,16'h1000,16'hFFFF,1));
    tbl.push_back(mk(0,0,0,16'h0000,15'h0000,0,0,1,0, 0,12,11,16'h1000,16'hFFFF,1));
    tbl.push_back(mk(0,0,0,16'h0000,15'h0000,0,0,1,0, 0,12,11,16'h1000,16'hFFFF,1));
    tbl.push_back(mk(0,0,0,16'h0000,15'h0000,0,0,0,0, 1,12,11,16'h1000,16'hFFFF,1));
    tbl.push_back(mk(0,0,1,16'h0300,15'h0000,0,0,1,1, 0,12,12,16'h1000,16'hFFFF,0));
    tbl.push_back(mk(0,0,1,16'h0100,15'h0000,0,0,0,0, 0,12, 1,16'h1000,16'hFFFF,1));
    tbl.push_back(mk(0,0,0,16'h0000,15'h0000,0,0,0,0, 1,12, 1,16'h1000,16'hFFFF,1));
    tbl.push_back(mk(0,0,1,16'h0500,15'h0000,0,0,0,0, 1,12, 5,16'h1000,16'hFFFF,1));
    tbl.push_back(mk(0,0,0,16'h0000,15'h0000,0,0,0,1, 0,12,12,16'h1000,16'hFFFF,0));
    tbl.push_back(mk(0,0,0,16'h0000,15'h0000,0,0,1,0, 0,12,12,16'h1000,16'hFFFF,0));
    tbl.push_back(mk(1,0,1,16'h0000,15'h0000,0,0,1,0, 0,12, 0,16'h0000,16'hFFFF,0));
    tbl.push_back(mk(0,0,0,16'h0000,15'h0010,1,5,1,0, 0,12, 0,16'h0020,16'hFFFF,1));
    tbl.push_back(mk(0,0,0,16'h0000,15'h0000,1,5,1,0, 0,12, 0,16'h0000,16'hFFFF,0));
    tbl.push_back(mk(0,0,0,16'h0000,15'h0000,0,0,1,1, 0,12, 0,16'h0000,16'hFFFF,0));
    tbl.push_back(mk(0,0,0,16'h0000,15'h7FFF,0,0,1,0, 0,12, 0,16'hFFFE,16'hFFFF,1));
    tbl.push_back(mk(1,0,0,16'h0001,15'h0000,0,0,1,0, 0,12, 0,16'h0001,16'hFFFF,0));
    tbl.push_back(mk(0,0,0,16'h0000,15'h0000,1,0,0,0, 0,12, 0,16'h0001,16'hFFFF,0));
    tbl.push_back(mk(0,0,0,16'h0000,15'h0000,0,0,0,0, 0,12, 0,16'h0001,16'hFFFF,0));

    do_reset();
    chk("reset lvreq", int'(lvreq), 0);
    chk("reset lvnew", int'(lvnew), 0);
    chk("reset pil", int'(pil), 0);
    chk("reset pid", int'(pid), 0);
    chk("reset pie", int'(pie), 0);
    chk("reset intpend", int'(intpend), 0);

`ifndef CGA_INTR_IRQ_SYNC_EN
    foreach (tbl[i]) run_vec(i, tbl[i]);
`endif

    // IRQ-to-LVREQ latency, then reset in the middle of the handshake
    do_reset();
    ldpie = 1; fidb = 16'hFFFF; logsn = 0;
    step();
    ldpie = 0; fidb = '0; irq = 15'h0200;
    step();
    irq = '0;
    cnt = 1;
    while (!lvreq && cnt < 20) begin
      step();
      cnt++;
    end
    chk("irq_to_lvreq latency", cnt, LAT);
    chk("latency lvnew", int'(lvnew), 10);
    rst = 1;
    step();
    rst = 0;
    chk("midreset lvreq", int'(lvreq), 0);
    chk("midreset pid", int'(pid), 0);
    chk("midreset pie", int'(pie), 0);
    chk("midreset pil", int'(pil), 0);
    lvack = 1;
    step();
    lvack = 0;
    chk("post-reset ack pil", int'(pil), 0);
    chk("post-reset ack lvreq", int'(lvreq), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
